guvm_ifetch_feeder: RTL and testbench

Instruction-side feed stage placed directly upstream of the core's instruction-cache output port (icache_output). It buffers instructions pushed by the bench driver and returns one per core fetch request. It inserts programmable wait states and starvation stalls through the active-low hold. It also reports each delivered instruction to the scoreboard.

---
 rtl/guvm_ifetch_feeder.sv | 212 +++++++++++++++++++++
 tb/tb_guvm_ifetch_feeder.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/guvm_ifetch_feeder.sv
// guvm_ifetch_feeder
// Instruction feed stage sitting in front of the core's icache_output port.
// A driver pushes {exc, inst} words into a small FIFO. Each core fetch
// request returns one word, after an optional programmable number of wait
// states. If the FIFO runs dry, the stage stalls through the active-low hold.
// Every delivered word is also reported on the issued_* port for a scoreboard.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   push_valid_i/inst_i/exc_i  driver push channel, push_ready_o = FIFO not full
//   fetch_req_i, fetch_addr_i  single-cycle fetch request with its address
//   flush_i                    drop FIFO contents and abort any pending request
//   cfg_wait_i                 wait states, sampled with the request
//   ico_data_o/exception_o     instruction presented to the core
//   ico_hold_o                 active-low stall to the core
//   issued_valid/addr/inst_o   one-cycle report of each delivered instruction
//   fifo_count_o               current FIFO occupancy
//   stall_cycles_o             saturating count of cycles with ico_hold_o low
module guvm_ifetch_feeder #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] NOP_INST = 32'h0100_0000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      push_valid_i,
    input  logic [31:0]               push_inst_i,
    input  logic                      push_exc_i,
    output logic                      push_ready_o,
    input  logic                      fetch_req_i,
    input  logic [31:0]               fetch_addr_i,
    input  logic                      flush_i,
    input  logic [3:0]                cfg_wait_i,
    output logic [31:0]               ico_data_o,
    output logic                      ico_exception_o,
    output logic                      ico_hold_o,
    output logic                      issued_valid_o,
    output logic [31:0]               issued_addr_o,
    output logic [31:0]               issued_inst_o,
    output logic [$clog2(DEPTH):0]    fifo_count_o,
    output logic [15:0]               stall_cycles_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STARVE
    } state_e;

    state_e        state_q, state_d;
    logic [32:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ready_q, push_ready_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [31:0]   ico_data_q, ico_data_d;
    logic          ico_exc_q, ico_exc_d;
    logic          ico_hold_q, ico_hold_d;
    logic          iss_valid_q, iss_valid_d;
    logic [31:0]   iss_addr_q, iss_addr_d;
    logic [31:0]   iss_inst_q, iss_inst_d;
    logic [15:0]   stall_q, stall_d;

    logic          do_push;
    logic          do_pop;
    logic [31:0]   pop_addr;
    logic [32:0]   head;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        cnt_d        = cnt_q;
        req_addr_d   = req_addr_q;
        ico_data_d   = ico_data_q;
        ico_exc_d    = ico_exc_q;
        ico_hold_d   = ico_hold_q;
        iss_valid_d  = 1'b0;
        iss_addr_d   = iss_addr_q;
        iss_inst_d   = iss_inst_q;
        do_pop       = 1'b0;
        pop_addr     = req_addr_q;
        do_push      = push_valid_i && push_ready_q && !flush_i;
        // The counter looks at the hold value currently driven to the core.
        stall_d      = (!ico_hold_q && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;

        if (flush_i) begin
            state_d    = S_IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            ico_data_d = NOP_INST;
            ico_exc_d  = 1'b0;
            ico_hold_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fetch_req_i) begin
                        if (cfg_wait_i != 4'd0) begin
                            req_addr_d = fetch_addr_i;
                            cnt_d      = cfg_wait_i;
                            ico_hold_d = 1'b0;
                            state_d    = S_WAIT;
                        end else if (count_q != '0) begin
                            // Zero-wait hit: the address goes straight to issued_addr.
                            do_pop   = 1'b1;
                            pop_addr = fetch_addr_i;
                        end else begin
                            req_addr_d = fetch_addr_i;
                            ico_hold_d = 1'b0;
                            state_d    = S_STARVE;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q > 4'd1) begin
                        cnt_d = cnt_q - 4'd1;
                    end else if (count_q != '0) begin
                        do_pop     = 1'b1;
                        ico_hold_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_STARVE;
                    end
                end
                S_STARVE: begin
                    if (count_q != '0) begin
                        do_pop     = 1'b1;
                        ico_hold_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (do_pop) begin
                ico_data_d  = head[31:0];
                ico_exc_d   = head[32];
                iss_valid_d = 1'b1;
                iss_addr_d  = pop_addr;
                iss_inst_d  = head[31:0];
                rd_ptr_d    = rd_ptr_q + 1'b1;
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end

        // Registered so push_ready_o tracks the occupancy it is derived from.
        push_ready_d = (count_d != CW'(DEPTH));
    end

    // Storage has no reset. Its contents only matter behind the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= {push_exc_i, push_inst_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            push_ready_q <= 1'b1;
            cnt_q        <= 4'd0;
            req_addr_q   <= 32'd0;
            ico_data_q   <= NOP_INST;
            ico_exc_q    <= 1'b0;
            ico_hold_q   <= 1'b1;
            iss_valid_q  <= 1'b0;
            iss_addr_q   <= 32'd0;
            iss_inst_q   <= 32'd0;
            stall_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            push_ready_q <= push_ready_d;
            cnt_q        <= cnt_d;
            req_addr_q   <= req_addr_d;
            ico_data_q   <= ico_data_d;
            ico_exc_q    <= ico_exc_d;
            ico_hold_q   <= ico_hold_d;
            iss_valid_q  <= iss_valid_d;
            iss_addr_q   <= iss_addr_d;
            iss_inst_q   <= iss_inst_d;
            stall_q      <= stall_d;
        end
    end

    assign push_ready_o    = push_ready_q;
    assign ico_data_o      = ico_data_q;
    assign ico_exception_o = ico_exc_q;
    assign ico_hold_o      = ico_hold_q;
    assign issued_valid_o  = iss_valid_q;
    assign issued_addr_o   = iss_addr_q;
    assign issued_inst_o   = iss_inst_q;
    assign fifo_count_o    = count_q;
    assign stall_cycles_o  = stall_q;

endmodule

// File: tb/tb_guvm_ifetch_feeder.sv
// Testbench for guvm_ifetch_feeder: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model.
module tb_guvm_ifetch_feeder;

    localparam int          DEPTH = 8;
    localparam logic [31:0] NOP   = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push_valid = 1'b0;
    logic [31:0] push_inst = 32'd0;
    logic        push_exc = 1'b0;
    logic        push_ready;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = 32'd0;
    logic        flush = 1'b0;
    logic [3:0]  cfg_wait = 4'd0;
    logic [31:0] ico_data;
    logic        ico_exception;
    logic        ico_hold;
    logic        issued_valid;
    logic [31:0] issued_addr;
    logic [31:0] issued_inst;
    logic [3:0]  fifo_count;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;
    bit mchk_en  = 1'b0;

    always #5 clk = ~clk;

    guvm_ifetch_feeder #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .push_valid_i   (push_valid),
        .push_inst_i    (push_inst),
        .push_exc_i     (push_exc),
        .push_ready_o   (push_ready),
        .fetch_req_i    (fetch_req),
        .fetch_addr_i   (fetch_addr),
        .flush_i        (flush),
        .cfg_wait_i     (cfg_wait),
        .ico_data_o     (ico_data),
        .ico_exception_o(ico_exception),
        .ico_hold_o     (ico_hold),
        .issued_valid_o (issued_valid),
        .issued_addr_o  (issued_addr),
        .issued_inst_o  (issued_inst),
        .fifo_count_o   (fifo_count),
        .stall_cycles_o (stall_cycles)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of words and at most one outstanding request
    // that becomes deliverable at edge 'm_due' (request edge plus the wait
    // count, at least one). It is delivered at the first edge from then on
    // that finds the queue non-empty. Hold is low exactly while a request is
    // outstanding.
    // ------------------------------------------------------------------
    logic [32:0] mq[$];
    bit          m_pending;
    int          m_due;
    int          edge_n;
    logic [31:0] m_paddr;
    logic [31:0] m_data;
    logic        m_exc;
    logic        m_valid;
    logic [31:0] m_iaddr;
    logic [31:0] m_iinst;
    logic [15:0] m_stall;
    int          sz;
    logic [32:0] ent;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pending = 1'b0;
            m_due     = 0;
            edge_n    = 0;
            m_paddr   = 32'd0;
            m_data    = NOP;
            m_exc     = 1'b0;
            m_valid   = 1'b0;
            m_iaddr   = 32'd0;
            m_iinst   = 32'd0;
            m_stall   = 16'd0;
        end else begin
            sz = mq.size();
            if (m_pending && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            m_valid = 1'b0;
            if (flush) begin
                mq.delete();
                m_pending = 1'b0;
                m_data    = NOP;
                m_exc     = 1'b0;
            end else begin
                if (m_pending) begin
                    if (edge_n >= m_due && sz > 0) begin
                        ent       = mq.pop_front();
                        m_data    = ent[31:0];
                        m_exc     = ent[32];
                        m_valid   = 1'b1;
                        m_iaddr   = m_paddr;
                        m_iinst   = ent[31:0];
                        m_pending = 1'b0;
                    end
                end else if (fetch_req) begin
                    if (cfg_wait == 4'd0 && sz > 0) begin
                        ent     = mq.pop_front();
                        m_data  = ent[31:0];
                        m_exc   = ent[32];
                        m_valid = 1'b1;
                        m_iaddr = fetch_addr;
                        m_iinst = ent[31:0];
                    end else begin
                        m_pending = 1'b1;
                        m_paddr   = fetch_addr;
                        m_due     = edge_n + ((cfg_wait == 4'd0) ? 1 : int'(cfg_wait));
                    end
                end
                if (push_valid && sz != DEPTH) mq.push_back({push_exc, push_inst});
            end
            if (m_valid) $display("issue addr=%h inst=%h exc=%b", m_iaddr, m_iinst, m_exc);
            edge_n++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && mchk_en) begin
            chk("model ico_data", ico_data, m_data);
            chk("model ico_exception", ico_exception, m_exc);
            chk("model ico_hold", ico_hold, !m_pending);
            chk("model issued_valid", issued_valid, m_valid);
            chk("model issued_addr", issued_addr, m_iaddr);
            chk("model issued_inst", issued_inst, m_iinst);
            chk("model fifo_count", fifo_count, mq.size());
            chk("model push_ready", push_ready, mq.size() != DEPTH);
            chk("model stall_cycles", stall_cycles, m_stall);
        end
    end

    // ------------------------------------------------------------------
    // Directed vector table: one row per cycle, expected outputs after the edge
    // ------------------------------------------------------------------
    typedef struct {
        logic        pv;
        logic [31:0] pi;
        logic        pe;
        logic        fr;
        logic [31:0] fa;
        logic [3:0]  cw;
        logic        fl;
        logic        e_hold;
        logic        e_valid;
        logic        e_exc;
        logic [31:0] e_data;
        logic [3:0]  e_cnt;
        logic [15:0] e_stall;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic pv, input logic [31:0] pi, input logic pe,
                                input logic fr, input logic [31:0] fa, input logic [3:0] cw,
                                input logic fl, input logic eh, input logic ev, input logic ee,
                                input logic [31:0] ed, input logic [3:0] ec,
                                input logic [15:0] es, input logic [31:0] ea);
        vec_t v;
        v.pv = pv; v.pi = pi; v.pe = pe; v.fr = fr; v.fa = fa; v.cw = cw; v.fl = fl;
        v.e_hold = eh; v.e_valid = ev; v.e_exc = ee; v.e_data = ed; v.e_cnt = ec;
        v.e_stall = es; v.e_addr = ea;
        vq.push_back(v);
    endfunction

    task automatic idle_inputs();
        push_valid = 1'b0; push_inst = 32'd0; push_exc = 1'b0;
        fetch_req  = 1'b0; fetch_addr = 32'd0; cfg_wait = 4'd0; flush = 1'b0;
    endtask

    task automatic fetch0(input logic [31:0] a);
        idle_inputs();
        fetch_req = 1'b1; fetch_addr = a; cfg_wait = 4'd0;
    endtask

    logic [31:0] order[$];
    logic [31:0] w;

    initial begin
        // hit with zero wait
        add(1, 32'h8E00C002, 0, 0, 0, 0, 0,   1, 0, 0, NOP,          1, 0, 0);
        add(0, 0, 0, 1, 32'h4000_0000, 0, 0,  1, 1, 0, 32'h8E00C002, 0, 0, 32'h4000_0000);
        add(0, 0, 0, 0, 0, 0, 0,              1, 0, 0, 32'h8E00C002, 0, 0, 0);
        // three wait states
        add(1, 32'h1111_1111, 0, 0, 0, 0, 0,  1, 0, 0, 32'h8E00C002, 1, 0, 0);
        add(1, 32'h2222_2222, 0, 0, 0, 0, 0,  1, 0, 0, 32'h8E00C002, 2, 0, 0);
        add(0, 0, 0, 1, 32'h100, 3, 0,        0, 0, 0, 32'h8E00C002, 2, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 32'h8E00C002, 2, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 32'h8E00C002, 2, 2, 0);
        add(0, 0, 0, 0, 0, 0, 0,              1, 1, 0, 32'h1111_1111, 1, 3, 32'h100);
        add(0, 0, 0, 1, 32'h104, 0, 0,        1, 1, 0, 32'h2222_2222, 0, 3, 32'h104);
        // starvation, word arrives five cycles after the request
        add(0, 0, 0, 1, 32'h200, 0, 0,        0, 0, 0, 32'h2222_2222, 0, 3, 0);
        add(0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 32'h2222_2222, 0, 4, 0);
        add(0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 32'h2222_2222, 0, 5, 0);
        add(0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 32'h2222_2222, 0, 6, 0);
        add(0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 32'h2222_2222, 0, 7, 0);
        add(1, 32'h0100_0000, 0, 0, 0, 0, 0,  0, 0, 0, 32'h2222_2222, 1, 8, 0);
        add(0, 0, 0, 0, 0, 0, 0,              1, 1, 0, 32'h0100_0000, 0, 9, 32'h200);
        add(0, 0, 0, 0, 0, 0, 0,              1, 0, 0, 32'h0100_0000, 0, 9, 0);
        // flush during WAIT with a simultaneous push and fetch
        add(1, 32'hA000_0000, 0, 0, 0, 0, 0,  1, 0, 0, 32'h0100_0000, 1, 9, 0);
        add(1, 32'hA000_0001, 0, 0, 0, 0, 0,  1, 0, 0, 32'h0100_0000, 2, 9, 0);
        add(1, 32'hA000_0002, 0, 0, 0, 0, 0,  1, 0, 0, 32'h0100_0000, 3, 9, 0);
        add(1, 32'hA000_0003, 0, 0, 0, 0, 0,  1, 0, 0, 32'h0100_0000, 4, 9, 0);
        add(0, 0, 0, 1, 32'h300, 5, 0,        0, 0, 0, 32'h0100_0000, 4, 9, 0);
        add(1, 32'hAAAA_AAAA, 0, 1, 32'h304, 0, 1, 1, 0, 0, NOP,         0, 10, 0);
        add(0, 0, 0, 0, 0, 0, 0,              1, 0, 0, NOP,          0, 10, 0);
        // exception bit travels with its word
        add(1, 32'h3333_3333, 1, 0, 0, 0, 0,  1, 0, 0, NOP,          1, 10, 0);
        add(0, 0, 0, 1, 32'h400, 0, 0,        1, 1, 1, 32'h3333_3333, 0, 10, 32'h400);
        add(0, 0, 0, 0, 0, 0, 0,              1, 0, 1, 32'h3333_3333, 0, 10, 0);

        // reset and reset-state checks
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ico_data", ico_data, NOP);
        chk("reset ico_exception", ico_exception, 1'b0);
        chk("reset ico_hold", ico_hold, 1'b1);
        chk("reset issued_valid", issued_valid, 1'b0);
        chk("reset issued_addr", issued_addr, 32'd0);
        chk("reset issued_inst", issued_inst, 32'd0);
        chk("reset fifo_count", fifo_count, 4'd0);
        chk("reset push_ready", push_ready, 1'b1);
        chk("reset stall_cycles", stall_cycles, 16'd0);
        rst_n   = 1'b1;
        mchk_en = 1'b1;

        foreach (vq[i]) begin
            push_valid = vq[i].pv; push_inst = vq[i].pi; push_exc = vq[i].pe;
            fetch_req  = vq[i].fr; fetch_addr = vq[i].fa; cfg_wait = vq[i].cw;
            flush      = vq[i].fl;
            @(negedge clk);
            chk($sformatf("row%0d ico_hold", i), ico_hold, vq[i].e_hold);
            chk($sformatf("row%0d issued_valid", i), issued_valid, vq[i].e_valid);
            chk($sformatf("row%0d ico_exception", i), ico_exception, vq[i].e_exc);
            chk($sformatf("row%0d ico_data", i), ico_data, vq[i].e_data);
            chk($sformatf("row%0d fifo_count", i), fifo_count, vq[i].e_cnt);
            chk($sformatf("row%0d stall_cycles", i), stall_cycles, vq[i].e_stall);
            if (vq[i].e_valid) chk($sformatf("row%0d issued_addr", i), issued_addr, vq[i].e_addr);
        end
        idle_inputs();

        // fill to full, push refused when full, push+fetch at count 7
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            w = 32'hB000_0000 + 32'(i);
            push_valid = 1'b1; push_inst = w;
            order.push_back(w);
            @(negedge clk);
        end
        idle_inputs();
        chk("full push_ready", push_ready, 1'b0);
        chk("full fifo_count", fifo_count, 4'd8);
        push_valid = 1'b1; push_inst = 32'hDEAD_0000;
        @(negedge clk);
        chk("full drop fifo_count", fifo_count, 4'd8);
        fetch0(32'h500);
        @(negedge clk);
        w = order.pop_front();
        chk("drain issued_inst", issued_inst, w);
        chk("drain fifo_count", fifo_count, 4'd7);
        fetch0(32'h504);
        push_valid = 1'b1; push_inst = 32'hB000_0008;
        order.push_back(32'hB000_0008);
        @(negedge clk);
        w = order.pop_front();
        chk("pushpop issued_inst", issued_inst, w);
        chk("pushpop fifo_count", fifo_count, 4'd7);
        for (int i = 0; i < 7; i++) begin
            fetch0(32'h600 + 32'(4 * i));
            @(negedge clk);
            w = order.pop_front();
            chk($sformatf("order%0d issued_inst", i), issued_inst, w);
            chk($sformatf("order%0d issued_valid", i), issued_valid, 1'b1);
        end
        idle_inputs();
        @(negedge clk);
        chk("drained fifo_count", fifo_count, 4'd0);

        // asynchronous reset in the middle of a WAIT
        push_valid = 1'b1; push_inst = 32'hC0DE_0001;
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 32'h700; cfg_wait = 4'd6; push_valid = 1'b0;
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("midwait ico_hold", ico_hold, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async ico_data", ico_data, NOP);
        chk("async ico_exception", ico_exception, 1'b0);
        chk("async ico_hold", ico_hold, 1'b1);
        chk("async issued_valid", issued_valid, 1'b0);
        chk("async issued_addr", issued_addr, 32'd0);
        chk("async issued_inst", issued_inst, 32'd0);
        chk("async fifo_count", fifo_count, 4'd0);
        chk("async push_ready", push_ready, 1'b1);
        chk("async stall_cycles", stall_cycles, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("postreset issued_valid", issued_valid, 1'b0);
        chk("postreset ico_hold", ico_hold, 1'b1);

        // randomized traffic checked by the model
        for (int c = 0; c < 500; c++) begin
            push_valid = ($urandom_range(0, 99) < 55);
            push_inst  = $urandom;
            push_exc   = ($urandom_range(0, 9) == 0);
            fetch_req  = ($urandom_range(0, 99) < 35);
            fetch_addr = $urandom & 32'hFFFF_FFFC;
            cfg_wait   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                     : 4'($urandom_range(0, 2));
            flush      = ($urandom_range(0, 99) < 3);
            @(negedge clk);
        end
        idle_inputs();
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
